// File: rtl/shift_issue_stage_if.sv
// rtl/shift_issue_stage_if.sv - handshake bundle between upstream decode, the shift issue stage and the barrel shifter
//
// Purpose: groups the instruction input side (in_valid/in_ready/inst/rs_val/rt_val)
// and the shifter output side (out_valid/out_ready/d/sa/right/arith/rd).
// Modports:
//   slave  - the issue stage: consumes instructions, presents shift operations
//   master - the surrounding environment: offers instructions, consumes shift operations
interface shift_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic [4:0]  sa;
  logic        right;
  logic        arith;
  logic [4:0]  rd;

  modport slave (
    input  in_valid, inst, rs_val, rt_val, out_ready,
    output in_ready, out_valid, d, sa, right, arith, rd
  );

  modport master (
    output in_valid, inst, rs_val, rt_val, out_ready,
    input  in_ready, out_valid, d, sa, right, arith, rd
  );
endinterface

// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - decodes MIPS shift instructions into a 2-entry skid buffer feeding a barrel shifter
//
// Purpose: accepts instructions, keeps only sll/srl/sra/sllv/srlv/srav, and queues
// them (FIFO, 2 entries) as {d, sa, right, arith, rd} for the shifter. Non-shift
// instructions are dropped and counted in a saturating 8-bit counter.
// Ports:
//   clk      - clock, rising edge
//   clrn     - asynchronous active-low reset
//   flush    - synchronous discard of all buffered entries (beats any handshake)
//   bus      - shift_issue_stage_if.slave: instruction input and shift output handshakes
//   skip_cnt - number of accepted non-shift instructions, saturates at 255
module shift_issue_stage #(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      clrn,
  input  logic                      flush,
  shift_issue_stage_if.slave        bus,
  output logic [7:0]                skip_cnt
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  sa;
    logic        right;
    logic        arith;
    logic [4:0]  rd;
  } entry_t;

  entry_t     head_q;
  entry_t     tail_q;
  entry_t     new_e;
  logic [1:0] count_q;
  logic [1:0] count_next;
  logic       ready_q;
  logic       is_shift;
  logic       accept;
  logic       push;
  logic       pop;

  // Shift functs are 000000/000010/000011/000100/000110/000111: bit 2 selects
  // the variable form, bit 1 the right direction, bit 0 (with bit 1) sign fill.
  always_comb begin
    is_shift    = (bus.inst[31:26] == 6'd0) && (bus.inst[5:3] == 3'd0) &&
                  (bus.inst[1:0] != 2'b01);
    new_e.d     = bus.rt_val;
    new_e.sa    = bus.inst[2] ? bus.rs_val[4:0] : bus.inst[10:6];
    new_e.right = bus.inst[1];
    new_e.arith = bus.inst[1] & bus.inst[0];
    new_e.rd    = bus.inst[15:11];
  end

  assign accept = bus.in_valid & ready_q & ~flush;
  assign push   = accept & is_shift;
  assign pop    = (count_q != 2'd0) & bus.out_ready & ~flush;

  always_comb begin
    count_next = count_q;
    if (flush) begin
      count_next = 2'd0;
    end else if (push && !pop) begin
      count_next = count_q + 2'd1;
    end else if (pop && !push) begin
      count_next = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_q  <= 2'd0;
      ready_q  <= 1'b1;
      head_q   <= '0;
      tail_q   <= '0;
      skip_cnt <= 8'd0;
    end else begin
      count_q <= count_next;
      // in_ready is registered from the next occupancy, so out_ready never
      // reaches in_ready combinationally.
      ready_q <= (count_next != FULL);
      if (pop) begin
        // A push alongside a pop can only happen with one entry held (a full
        // buffer deasserts in_ready), so the new entry becomes the head.
        head_q <= push ? new_e : tail_q;
      end else if (push) begin
        if (count_q == 2'd0) begin
          head_q <= new_e;
        end else begin
          tail_q <= new_e;
        end
      end
      if (accept && !is_shift && skip_cnt != 8'hff) begin
        skip_cnt <= skip_cnt + 8'd1;
      end
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.d         = head_q.d;
  assign bus.sa        = head_q.sa;
  assign bus.right     = head_q.right;
  assign bus.arith     = head_q.arith;
  assign bus.rd        = head_q.rd;

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - scoreboard bench for shift_issue_stage
module tb_shift_issue_stage;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  sa;
    logic        right;
    logic        arith;
    logic [4:0]  rd;
  } ent_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rs;
    logic [31:0] rt;
  } req_t;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] skip_cnt;
  int         total = 0;
  int         bad = 0;
  int         exp_skip = 0;
  ent_t       sb[$];

  shift_issue_stage_if bus ();

  shift_issue_stage #(.DEPTH(2)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .flush    (flush),
    .bus      (bus),
    .skip_cnt (skip_cnt)
  );

  always #5 clk = ~clk;

  wire ent_t obs = {bus.d, bus.sa, bus.right, bus.arith, bus.rd};

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sa,
                                     input logic [5:0] f);
    return {6'd0, rs, rt, rd, sa, f};
  endfunction

  // Reference decode, written from the instruction table.
  function automatic logic decode(input logic [31:0] i, input logic [31:0] rs,
                                  input logic [31:0] rt, output ent_t e);
    logic hit;
    hit     = 1'b1;
    e.d     = rt;
    e.rd    = i[15:11];
    e.sa    = i[10:6];
    e.right = 1'b0;
    e.arith = 1'b0;
    case (i[5:0])
      6'b000000: ;
      6'b000010: e.right = 1'b1;
      6'b000011: begin e.right = 1'b1; e.arith = 1'b1; end
      6'b000100: e.sa = rs[4:0];
      6'b000110: begin e.sa = rs[4:0]; e.right = 1'b1; end
      6'b000111: begin e.sa = rs[4:0]; e.right = 1'b1; e.arith = 1'b1; end
      default:   hit = 1'b0;
    endcase
    return hit && (i[31:26] == 6'd0);
  endfunction

  // Drives one cycle (inputs set just after a rising edge) and updates the scoreboard
  // for whatever the edge accepts or pops. Returns with time at edge + 1.
  task automatic step(input logic iv, input logic [31:0] i, input logic [31:0] rs,
                      input logic [31:0] rt, input logic ordy, input logic fl,
                      output logic acc);
    ent_t e;
    logic sh;
    logic pop;
    bus.in_valid  = iv;
    bus.inst      = i;
    bus.rs_val    = rs;
    bus.rt_val    = rt;
    bus.out_ready = ordy;
    flush         = fl;
    acc = iv && !fl && (sb.size() < 2);
    pop = ordy && !fl && (sb.size() > 0);
    sh  = decode(i, rs, rt, e);
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (acc && sh) sb.push_back(e);
      if (acc && !sh && exp_skip < 255) exp_skip++;
    end
  endtask

  task automatic idle(input logic ordy);
    logic a;
    step(1'b0, 32'h0, 32'h0, 32'h0, ordy, 1'b0, a);
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.inst = '0; bus.rs_val = '0; bus.rt_val = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (skip_cnt !== 8'd0) begin bad++; $display("FAIL reset_skip got=%0d want=0", skip_cnt); end
    total++; if (obs !== ent_t'(0)) begin bad++; $display("FAIL reset_head got=%h want=0", obs); end
    clrn = 1'b1;
  endtask

  task automatic test_single(input string name, input logic [31:0] i, input logic [31:0] rs,
                             input logic [31:0] rt, input ent_t want);
    logic a;
    step(1'b1, i, rs, rt, 1'b1, 1'b0, a);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b want=1", name, bus.out_valid); end
    total++; if (obs !== want) begin bad++; $display("FAIL %s_fields got=%h want=%h", name, obs, want); end
    total++; if (sb.size() == 0 || obs !== sb[0]) begin bad++; $display("FAIL %s_sb got=%h want=%h", name, obs, want); end
    idle(1'b1);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL %s_drain got=%b want=0", name, bus.out_valid); end
  endtask

  task automatic test_back_to_back;
    req_t pend[$];
    ent_t first;
    logic a;
    int   n;
    void'(decode(mk(5'd0, 5'd2, 5'd1, 5'd3, 6'b000010), 32'h0, 32'h80000001, first));
    pend.push_back('{mk(5'd0, 5'd2, 5'd1, 5'd3, 6'b000010), 32'h0, 32'h80000001});
    pend.push_back('{mk(5'd4, 5'd2, 5'd7, 5'd0, 6'b000100), 32'h0000003f, 32'h12345678});
    pend.push_back('{mk(5'd4, 5'd2, 5'd9, 5'd0, 6'b000111), 32'h00000010, 32'h87654321});
    pend.push_back('{mk(5'd0, 5'd2, 5'd31, 5'd31, 6'b000011), 32'h0, 32'hdeadbeef});
    for (int k = 0; k < 3; k++) begin
      step(1'b1, pend[0].inst, pend[0].rs, pend[0].rt, 1'b0, 1'b0, a);
      if (a) void'(pend.pop_front());
    end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b want=0", bus.in_ready); end
    total++; if (obs !== first) begin bad++; $display("FAIL b2b_stall_head got=%h want=%h", obs, first); end
    n = 0;
    while ((pend.size() > 0 || sb.size() > 0) && n < 12) begin
      if (pend.size() > 0) begin
        step(1'b1, pend[0].inst, pend[0].rs, pend[0].rt, 1'b1, 1'b0, a);
        if (a) void'(pend.pop_front());
      end else begin
        idle(1'b1);
      end
      total++; if (bus.out_valid !== (sb.size() != 0)) begin bad++; $display("FAIL b2b_valid got=%b want=%b", bus.out_valid, sb.size() != 0); end
      total++; if (bus.in_ready !== (sb.size() < 2)) begin bad++; $display("FAIL b2b_ready got=%b want=%b", bus.in_ready, sb.size() < 2); end
      if (sb.size() > 0) begin
        total++; if (obs !== sb[0]) begin bad++; $display("FAIL b2b_order got=%h want=%h", obs, sb[0]); end
      end
      n++;
    end
    total++; if (n >= 12) begin bad++; $display("FAIL b2b_timeout got=%0d want<12", n); end
  endtask

  task automatic test_flush;
    ent_t g;
    logic a;
    step(1'b1, mk(5'd0, 5'd1, 5'd2, 5'd1, 6'b000000), 0, 32'h1, 1'b0, 1'b0, a);
    step(1'b1, mk(5'd0, 5'd1, 5'd3, 5'd2, 6'b000010), 0, 32'h2, 1'b0, 1'b0, a);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_full got=%b want=0", bus.in_ready); end
    void'(decode(mk(5'd0, 5'd1, 5'd4, 5'd9, 6'b000011), 0, 32'hcafe0000, g));
    step(1'b1, mk(5'd0, 5'd1, 5'd4, 5'd9, 6'b000011), 0, 32'hcafe0000, 1'b1, 1'b1, a);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", bus.in_ready); end
    step(1'b1, 32'h20010005, 0, 0, 1'b0, 1'b1, a);
    total++; if (skip_cnt !== 8'(exp_skip)) begin bad++; $display("FAIL flush_skip got=%0d want=%0d", skip_cnt, exp_skip); end
    step(1'b1, mk(5'd0, 5'd1, 5'd4, 5'd9, 6'b000011), 0, 32'hcafe0000, 1'b0, 1'b0, a);
    total++; if (bus.out_valid !== 1'b1 || obs !== g) begin bad++; $display("FAIL flush_refill got=%h want=%h", obs, g); end
    idle(1'b1);
  endtask

  task automatic test_skip;
    logic a;
    int   vbad;
    vbad = 0;
    for (int k = 0; k < 300; k++) begin
      step(1'b1, 32'h20010005, 32'h0, 32'h0, 1'b1, 1'b0, a);
      if (bus.out_valid !== 1'b0) vbad++;
    end
    total++; if (vbad != 0) begin bad++; $display("FAIL skip_valid got=%0d want=0 cycles", vbad); end
    total++; if (skip_cnt !== 8'(exp_skip)) begin bad++; $display("FAIL skip_model got=%0d want=%0d", skip_cnt, exp_skip); end
    total++; if (skip_cnt !== 8'd255) begin bad++; $display("FAIL skip_sat got=%0d want=255", skip_cnt); end
  endtask

  task automatic test_reset_mid;
    ent_t e;
    logic a;
    step(1'b1, mk(5'd0, 5'd1, 5'd2, 5'd5, 6'b000000), 0, 32'h11, 1'b0, 1'b0, a);
    step(1'b1, mk(5'd0, 5'd1, 5'd3, 5'd6, 6'b000000), 0, 32'h22, 1'b0, 1'b0, a);
    bus.in_valid = 1'b0;
    clrn = 1'b0;
    #1;
    sb.delete();
    exp_skip = 0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready got=%b want=1", bus.in_ready); end
    total++; if (skip_cnt !== 8'd0) begin bad++; $display("FAIL mid_reset_skip got=%0d want=0", skip_cnt); end
    @(posedge clk);
    #1;
    clrn = 1'b1;
    void'(decode(mk(5'd3, 5'd1, 5'd12, 5'd0, 6'b000110), 32'h7, 32'h5a5a5a5a, e));
    step(1'b1, mk(5'd3, 5'd1, 5'd12, 5'd0, 6'b000110), 32'h7, 32'h5a5a5a5a, 1'b1, 1'b0, a);
    total++; if (bus.out_valid !== 1'b1 || obs !== e) begin bad++; $display("FAIL first_accept got=%h want=%h", obs, e); end
    idle(1'b1);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL no_reappear got=%b want=0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_single("sll", 32'h00084200, 32'h0, 32'hff0000ff, {32'hff0000ff, 5'd8, 1'b0, 1'b0, 5'd8});
    test_single("sra", 32'h00081903, 32'h0, 32'hff0000ff, {32'hff0000ff, 5'd4, 1'b1, 1'b1, 5'd3});
    test_single("srav", 32'h00082807, 32'h00000022, 32'h0000f00d, {32'h0000f00d, 5'd2, 1'b1, 1'b1, 5'd5});
    test_back_to_back();
    test_flush();
    test_skip();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
